// File: rtl/pressure_scan_scheduler_pkg.sv
// Shared types and defaults for the pressure scan scheduler.
// Holds the scan FSM state type and the persistence counter width helper.
package health_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scanState_e;

    localparam int NUM_CH_DEF  = 4;
    localparam int DW_DEF      = 6;
    localparam int PERSIST_DEF = 3;

    // Counter must be able to hold the value PERSIST itself.
    function automatic int cntWidth(input int persist);
        return $clog2(persist + 1);
    endfunction

    localparam int CNT_W_DEF = $clog2(PERSIST_DEF + 1);

endpackage

// File: rtl/pressure_scan_scheduler_persist_counter.sv
// Per-channel persistence counter with sticky alarm.
// Counts consecutive abnormal evaluations; raises alarm on reaching PERSIST.
module persist_counter #(
    parameter int PERSIST = 3,
    parameter int CW      = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          eval,
    input  logic          abnormal,
    input  logic          ack,
    output logic          alarm,
    output logic [CW-1:0] count,
    output logic          alarmNext
);

    localparam logic [CW:0] PW  = (CW+1)'(PERSIST);
    localparam logic [CW:0] ONE = (CW+1)'(1);

    logic          ackEff;
    logic          setAlarm;
    logic [CW-1:0] base;
    logic [CW:0]   incWide;
    logic [CW:0]   oldInc;
    logic [CW-1:0] countNext;

    // Ack only acts on a raised alarm; set is judged on the pre-ack count
    // so that an ack landing on a re-setting edge cannot suppress the alarm.
    always_comb begin
        ackEff    = ack & alarm;
        base      = ackEff ? '0 : count;
        incWide   = {1'b0, base} + ONE;
        oldInc    = {1'b0, count} + ONE;
        setAlarm  = eval & abnormal & (oldInc >= PW);
        countNext = base;
        if (eval) begin
            if (abnormal) begin
                if (incWide >= PW) begin
                    countNext = PW[CW-1:0];
                end else begin
                    countNext = incWide[CW-1:0];
                end
            end else begin
                countNext = '0;
            end
        end
        alarmNext = setAlarm | (alarm & ~ackEff);
    end

    // Counter and alarm state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            alarm <= 1'b0;
        end else begin
            count <= countNext;
            alarm <= alarmNext;
        end
    end

endmodule

// File: rtl/pressure_scan_scheduler.sv
// Time-shares one pressure detector across NUM_CH channels per sampleTick.
// Optional macro SCAN_OVERRUN_EN adds a sticky overrun flag for dropped ticks.
module pressure_scan_scheduler
    import health_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int DW      = DW_DEF,
    parameter int PERSIST = PERSIST_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sampleTick,
    input  logic [NUM_CH*DW-1:0]      chanData,
    output logic [DW-1:0]             detPressure,
    input  logic                      detAbnormal,
    input  logic [NUM_CH-1:0]         alarmAck,
    output logic [NUM_CH-1:0]         alarm,
    output logic                      alarmAny,
    output logic                      scanBusy,
    output logic                      scanDone,
    output logic [$clog2(NUM_CH)-1:0] curChan
`ifdef SCAN_OVERRUN_EN
    ,
    output logic                      overrun
`endif
);

    localparam int CHW = $clog2(NUM_CH);
    localparam int CW  = cntWidth(PERSIST);
    localparam logic [CHW-1:0] LAST = CHW'(NUM_CH - 1);

    scanState_e        state;
    logic [NUM_CH-1:0] evalVec;
    logic [NUM_CH-1:0] alarmNextVec;
    logic [CW-1:0]     countVec [NUM_CH];

    // Scan sequencer: IDLE -> SCAN over all channels -> DONE -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            curChan <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sampleTick) begin
                        state   <= SCAN;
                        curChan <= '0;
                    end
                end
                SCAN: begin
                    if (curChan == LAST) begin
                        state <= DONE;
                    end else begin
                        curChan <= curChan + 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    curChan <= '0;
                end
                default: begin
                    state   <= IDLE;
                    curChan <= '0;
                end
            endcase
        end
    end

    // Route the channel under evaluation to the shared detector.
    always_comb begin
        detPressure = '0;
        if (state == SCAN) begin
            detPressure = chanData[int'(curChan)*DW +: DW];
        end
    end

    // Status flags decoded from the sequencer state.
    always_comb begin
        scanBusy = (state != IDLE);
        scanDone = (state == DONE);
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : gCh
        // Only the channel under evaluation consumes the verdict.
        always_comb begin
            evalVec[k] = (state == SCAN) && (curChan == CHW'(k));
        end

        persist_counter #(
            .PERSIST (PERSIST),
            .CW      (CW)
        ) uCnt (
            .clk       (clk),
            .rst       (rst),
            .eval      (evalVec[k]),
            .abnormal  (detAbnormal),
            .ack       (alarmAck[k]),
            .alarm     (alarm[k]),
            .count     (countVec[k]),
            .alarmNext (alarmNextVec[k])
        );

        // Saturation keeps every counter within 0..PERSIST.
        aCntRange: assert property (
            @(posedge clk) disable iff (rst)
            int'(countVec[k]) <= PERSIST
        );
    end

    // Summary alarm registered alongside the per-channel alarms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarmAny <= 1'b0;
        end else begin
            alarmAny <= |alarmNextVec;
        end
    end

`ifdef SCAN_OVERRUN_EN
    // Sticky record of a tick arriving while a scan is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (sampleTick && scanBusy) begin
            overrun <= 1'b1;
        end else if (sampleTick && (state == IDLE) && (&alarmAck)) begin
            overrun <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/pressure_scan_scheduler.md
Name: pressure_scan_scheduler

Overview:
- Shares one combinational pressure abnormality detector among NUM_CH patient pressure channels.
- On each sampleTick, scans the channels in order (0..NUM_CH-1), one per cycle, and presents each sample to the detector.
- Feeds each detector verdict into a per-channel persistence counter.
- Latches a sticky per-channel alarm once PERSIST consecutive abnormal scans occur. Sits between the sensor front-end registers and the alarm/display logic.

Parameters:
- NUM_CH, 4, number of pressure channels sharing the detector (>=2).
- DW, 6, pressure sample width; must match the detector input.
- PERSIST, 3, consecutive abnormal scans needed to raise an alarm (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sampleTick  in  1  one-cycle request to start a scan.
- chanData  in  NUM_CH*DW  packed samples; channel k occupies bits [k*DW +: DW].
- detPressure  out  DW  sample driven to the shared detector.
- detAbnormal  in  1  detector verdict, combinational from detPressure.
- alarmAck  in  NUM_CH  per-channel alarm clear.
- alarm  out  NUM_CH  sticky per-channel alarm.
- alarmAny  out  1  OR of alarm.
- scanBusy  out  1  high in SCAN or DONE.
- scanDone  out  1  one-cycle pulse in DONE.
- curChan  out  clog2(NUM_CH)  channel under evaluation.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; curChan=0.
  - All persistence counters = 0; alarm=0; alarmAny=0; scanBusy=0; scanDone=0; detPressure=0.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: on sampleTick=1, go to SCAN with curChan=0.
  - SCAN: each cycle, evaluate curChan.
    - If curChan==NUM_CH-1, go to DONE.
    - Otherwise curChan increments.
  - DONE: scanDone=1 for exactly one cycle, then IDLE; curChan returns to 0.
- Detector mux:
  - detPressure = chanData[curChan] combinationally while in SCAN; 0 otherwise.
  - detAbnormal is sampled at the clock edge that ends that SCAN cycle.
- Timing: sampleTick at edge t.
  - Channel k is evaluated during cycle t+1+k.
  - Its alarm update is visible after edge t+2+k.
  - scanDone is high in cycle t+1+NUM_CH.
  - Scan period = NUM_CH+1 cycles.
- Persistence counter, per channel, width clog2(PERSIST+1), updated only when that channel is evaluated:
  - detAbnormal=1: saturating increment, capped at PERSIST.
  - detAbnormal=0: cleared to 0.
  - alarm[k] sets on the edge where the counter reaches PERSIST. With PERSIST=1, one abnormal scan sets it.
- Alarm clear:
  - alarm[k] stays set until alarmAck[k]=1, which clears it and its counter.
  - Ack and set on the same edge for the same channel: set wins; the counter becomes 1 if PERSIST>1.
  - Ack of a channel with no alarm has no effect.
- sampleTick while scanBusy=1 is ignored; no queueing.
- chanData may change mid-scan. Each channel uses the value present in its own evaluation cycle.
- rst mid-scan aborts the scan immediately. No scanDone pulse; counters and alarms are lost.
- alarmAny is registered with alarm and updates on the same edge.

Optional Feature:
- Macro: SCAN_OVERRUN_EN.
- Defined:
  - Adds output overrun (1 bit), sticky.
  - Set when sampleTick=1 while scanBusy=1.
  - Cleared only by rst, or by sampleTick=1 accepted in IDLE with alarmAck all-ones.
  - Reset value 0.
- Not defined: the port is absent and overlapping ticks are silently dropped.

Decomposition:
- Package health_pkg holds:
  - state enum {IDLE, SCAN, DONE}.
  - Default constants NUM_CH_DEF=4, DW_DEF=6, PERSIST_DEF=3.
  - Width helper constant for counter width.
- One sub-module: persist_counter, instantiated NUM_CH times.
  - Inputs: clk, rst, eval, abnormal, ack.
  - Outputs: alarm bit, count.
- The FSM, curChan counter and detector mux live in the top.

Test Plan:
- Bench detector stub: detAbnormal = (detPressure >= 6'd44).
- Reset mid-scan: rst during SCAN with curChan=2 -> curChan=0, alarm=0, no scanDone, idle on release.
- Single tick, all chanData=6'd40 -> curChan steps 0,1,2,3; scanDone 5 cycles after tick; alarm=0.
- Channel 1 = 6'd44 for 3 ticks, others 0 -> alarm=4'b0010 after the 3rd scan's ch1 edge; alarmAny=1.
- Abnormal run broken: ch2 pattern 44,44,0,44,44,44 over 6 scans -> alarm[2] rises only after the 6th scan.
- Ack: alarmAck[1] pulsed in IDLE -> alarm[1]=0. Ack on the same edge as a re-set with PERSIST=1 -> alarm[1] stays 1.
- Overlap: sampleTick pulsed during SCAN -> ignored, one scanDone only. With SCAN_OVERRUN_EN, overrun=1 and stays 1.
